// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer/full control of the async FIFO: binary/Gray write pointer, 2-flop read-pointer
// synchronizer, registered full/level/overflow. Optional almost_full under FIFO_ALMOST_FULL_EN.
module fifo_wr_ptr_full #(
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  almost_full,
  output logic                  wr_overflow
);

  localparam int unsigned PtrW  = ADDR_WIDTH + 1;
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  // Out-of-range thresholds elaborate this empty block; it keeps the parameter referenced in
  // builds without the almost_full comparator.
  if (AFULL_THRESH < 1 || AFULL_THRESH > Depth) begin : g_afull_thresh_illegal
  end

  logic [PtrW-1:0] wbin_q, wbin_d;
  logic [PtrW-1:0] wgray_q, wgray_d;
  logic [PtrW-1:0] rq1_q, rq2_q;
  logic [PtrW-1:0] rbin_sync;
  logic [PtrW-1:0] level_q, level_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic            wr_inc;

  always_comb begin
    rbin_sync           = '0;
    rbin_sync[PtrW-1]   = rq2_q[PtrW-1];
    for (int i = int'(PtrW) - 2; i >= 0; i--) begin
      rbin_sync[i] = rbin_sync[i+1] ^ rq2_q[i];
    end
  end

  always_comb begin
    wr_inc  = wr_en & ~full_q;
    wbin_d  = wbin_q + {{(PtrW-1){1'b0}}, wr_inc};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    // Full when write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    full_d  = (wgray_d == {~rq2_q[PtrW-1:PtrW-2], rq2_q[PtrW-3:0]});
    level_d = wbin_d - rbin_sync;
    ovf_d   = ovf_q | (wr_en & full_q);
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rd_ptr_gray;
      rq2_q   <= rq1_q;
      level_q <= level_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [PtrW-1:0] AfullThr = PtrW'(AFULL_THRESH);

  logic afull_q, afull_d;

  always_comb begin
    afull_d = (level_d >= AfullThr);
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign almost_full = afull_q;
`else
  assign almost_full = 1'b0;
`endif

  assign wr_addr     = wbin_q[ADDR_WIDTH-1:0];
  assign wr_ptr_gray = wgray_q;
  assign full        = full_q;
  assign wr_level    = level_q;
  assign wr_overflow = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// Bench for fifo_wr_ptr_full: directed scenarios plus randomized traffic against an
// occupancy-count reference model. Honors FIFO_ALMOST_FULL_EN for almost_full expectations.
module tb_fifo_wr_ptr_full;

  localparam int AW    = 3;
  localparam int Depth = 8;
  localparam int Mod   = 16;
  localparam int Thr   = 6;

  logic          wr_clk = 1'b0;
  logic          wr_rst;
  logic          wr_en;
  logic [AW:0]   rd_ptr_gray;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_ptr_gray;
  logic          full;
  logic [AW:0]   wr_level;
  logic          almost_full;
  logic          wr_overflow;

  fifo_wr_ptr_full #(
    .ADDR_WIDTH  (AW),
    .AFULL_THRESH(Thr)
  ) dut (
    .wr_clk     (wr_clk),
    .wr_rst     (wr_rst),
    .wr_en      (wr_en),
    .rd_ptr_gray(rd_ptr_gray),
    .wr_addr    (wr_addr),
    .wr_ptr_gray(wr_ptr_gray),
    .full       (full),
    .wr_level   (wr_level),
    .almost_full(almost_full),
    .wr_overflow(wr_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: total writes and read position as plain counters modulo 16.
  int m_w, m_r1, m_r2, m_level;
  bit m_full, m_ovf;

`ifdef FIFO_ALMOST_FULL_EN
  localparam bit AfEn = 1'b1;
`else
  localparam bit AfEn = 1'b0;
`endif

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % Mod;
  endfunction

  function automatic void model_reset();
    m_w = 0; m_r1 = 0; m_r2 = 0; m_level = 0; m_full = 0; m_ovf = 0;
  endfunction

  function automatic void model_step(input bit we, input int rbin);
    if (we && m_full) m_ovf = 1;
    if (we && !m_full) m_w = (m_w + 1) % Mod;
    m_level = (m_w - m_r2 + Mod) % Mod;
    m_full  = (m_level == Depth);
    m_r2    = m_r1;
    m_r1    = rbin;
  endfunction

  task automatic check_all();
    check_eq("wr_addr", int'(wr_addr), m_w % Depth);
    check_eq("wr_ptr_gray", int'(wr_ptr_gray), to_gray(m_w));
    check_eq("full", int'(full), int'(m_full));
    check_eq("wr_level", int'(wr_level), m_level);
    check_eq("almost_full", int'(almost_full), (AfEn && m_level >= Thr) ? 1 : 0);
    check_eq("wr_overflow", int'(wr_overflow), int'(m_ovf));
  endtask

  task automatic cycle(input bit we, input int rbin);
    wr_en       = we;
    rd_ptr_gray = 4'(to_gray(rbin));
    @(posedge wr_clk);
    model_step(we, rbin);
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_addr"}, int'(wr_addr), 0);
    check_eq({tag, "_gray"}, int'(wr_ptr_gray), 0);
    check_eq({tag, "_full"}, int'(full), 0);
    check_eq({tag, "_level"}, int'(wr_level), 0);
    check_eq({tag, "_afull"}, int'(almost_full), 0);
    check_eq({tag, "_ovf"}, int'(wr_overflow), 0);
  endtask

  // Asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    wr_en = 1'b0;
    rd_ptr_gray = '0;
    #2 wr_rst = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge wr_clk);
    #3 wr_rst = 1'b0;
  endtask

  int gseq[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 12};
  int rc;

  initial begin
    wr_rst = 1'b1;
    wr_en = 1'b0;
    rd_ptr_gray = '0;
    model_reset();
    repeat (2) @(posedge wr_clk);
    #3 wr_rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 0);
      check_zero("idle");
    end

    // Fill with read pointer held at 0
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 0);
      check_eq("gray_seq", int'(wr_ptr_gray), gseq[k]);
      check_eq("addr_seq", int'(wr_addr), k % Depth);
      if (k == 6) check_eq("afull_at_6", int'(almost_full), AfEn ? 1 : 0);
      if (k == 5) check_eq("afull_at_5", int'(almost_full), 0);
    end
    check_eq("full_after_8", int'(full), 1);
    check_eq("level_after_8", int'(wr_level), 8);

    // Write while full: rejected, overflow sticks
    cycle(1'b1, 0);
    check_eq("ovf_gray_hold", int'(wr_ptr_gray), 12);
    check_eq("ovf_set", int'(wr_overflow), 1);

    // Read pointer moves to 1: visible at the third edge
    cycle(1'b0, 1);
    check_eq("rd1_e1_full", int'(full), 1);
    check_eq("rd1_e1_level", int'(wr_level), 8);
    cycle(1'b0, 1);
    check_eq("rd1_e2_full", int'(full), 1);
    check_eq("rd1_e2_level", int'(wr_level), 8);
    cycle(1'b0, 1);
    check_eq("rd1_e3_full", int'(full), 0);
    check_eq("rd1_e3_level", int'(wr_level), 7);

    // Random traffic; reader never passes what has been written
    rc = 1;
    for (int i = 0; i < 500; i++) begin
      if (rc != m_w && $urandom_range(0, 99) < ((i < 250) ? 25 : 55)) rc = (rc + 1) % Mod;
      cycle($urandom_range(0, 99) < 65, rc);
      check_eq("ovf_sticky", int'(wr_overflow), 1);
    end

    // Rollover: full at write 0 (wrapped) against read 8
    do_reset("rst_a");
    for (int k = 0; k < 8; k++) cycle(1'b1, 0);
    check_eq("wrap_full_a", int'(full), 1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8);
    check_eq("wrap_empty_level", int'(wr_level), 0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 8);
    check_eq("wrap_full_b", int'(full), 1);
    check_eq("wrap_gray_b", int'(wr_ptr_gray), 0);
    check_eq("wrap_ovf_clear", int'(wr_overflow), 0);

    // Asynchronous reset mid-burst at level 5
    do_reset("rst_b");
    for (int k = 0; k < 5; k++) cycle(1'b1, 0);
    check_eq("pre_rst_level", int'(wr_level), 5);
    do_reset("rst_mid");
    cycle(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
